mul32_seq: RTL and testbench
============================

// Module: mul32_seq
// PURPOSE
//  Iterative radix-2 shift-add multiplier serving ex_op 2'b10 (unsigned MUL) and 2'b11 (signed MUL).
//  Sits beside the EX-stage execution unit and feeds its operation mux for those two codes.
//  Takes the same A/B operands and drives a stall to the pipeline control while a product is in progress.
//  Produces the full 2*WIDTH-bit product.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH bits
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high reset
//  A           in   WIDTH    multiplicand, sampled only on an accepted start
//  B           in   WIDTH    multiplier, sampled only on an accepted start
//  start       in   1        request a multiply (EX decode: ex_op[1])
//  is_signed   in   1        1 = two's-complement operands (ex_op[0]), sampled with start
//  flush       in   1        abort the in-flight multiply (branch/exception flush)
//  product_lo  out  WIDTH    product bits [WIDTH-1:0], registered
//  product_hi  out  WIDTH    product bits [2*WIDTH-1:WIDTH], registered
//  done        out  1        one-cycle pulse: product valid
//  busy        out  1        high in RUN and FIX
//  stall       out  1        hold the upstream pipeline
// BEHAVIOUR
//  Reset: state=IDLE; product_lo/hi=0; done=0; busy=0; stall=0; counter and internal regs cleared.
//  States:
//   IDLE -> RUN on start.
//   RUN -> FIX after WIDTH iterations.
//   FIX -> DONE.
//   DONE -> IDLE, or DONE -> RUN if start.
//  Accept: start is accepted only in IDLE or DONE. start in RUN/FIX is ignored and does not queue.
//  Load on accept:
//   magA=|A|, magB=|B| if is_signed, else magA=A and magB=B.
//   neg = is_signed & (A[MSB]^B[MSB]).
//   acc=0; cnt=0.
//  RUN, one iteration per cycle:
//   if multiplier LSB is 1, add magA into the upper accumulator half with carry-out kept;
//   then shift {carry,acc,multiplier} right by 1.
//   cnt increments; on cnt==WIDTH-1 go to FIX.
//  FIX: product = neg ? -acc : acc (2*WIDTH-bit two's complement); register into product_hi/lo; go to DONE.
//  DONE: done=1 for exactly this cycle. Outputs stay stable until the next FIX writes them.
//  Latency: start high in cycle 0 (accepted), done high in cycle WIDTH+2 (34 at default). Fixed, data-independent.
//  Magnitude edge: |-2**(WIDTH-1)| = 2**(WIDTH-1) fits in unsigned WIDTH bits; no overflow path.
//  Zero operand with neg=1 yields all-zero product (negation of 0).
//  stall = busy | (start & (state==IDLE | state==DONE)).
//   Combinational, so the requesting instruction holds in EX from its first cycle.
//   stall deasserts in the DONE cycle, so the pipeline advances and captures the product.
//  flush (any state): next state IDLE; no done. product_lo/hi keep their previous values; busy/stall drop next cycle.
//  flush & start in the same cycle: flush wins; start is not accepted.
//  reset mid-operation: behaves as reset; all outputs 0 next cycle.
//  Back-to-back: start held in the DONE cycle begins the next multiply with no idle cycle.
// TESTING
//  1. Unsigned: A=0xFFFFFFFF, B=0xFFFFFFFF, is_signed=0 -> cycle 34: done=1, hi=0xFFFFFFFE, lo=0x00000001.
//  2. Signed: A=0xFFFFFFFF(-1), B=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9.
//     Signed: A=-1, B=-1 -> hi=0, lo=1.
//  3. Signed minimum: A=B=0x80000000 -> hi=0x40000000, lo=0; no overflow.
//     Unsigned: A=0x80000000, B=2 -> hi=1, lo=0.
//  4. Handshake: start pulse while busy at cycle 10 -> ignored; single done at cycle 34.
//     stall high cycles 0..33, low at cycle 34.
//  5. Flush at cycle 15 with start also high -> IDLE at cycle 16; no done.
//     Product regs keep the prior result; next start yields a correct result 34 cycles later.
//  6. Reset asserted at cycle 20 of a multiply -> next cycle: all outputs 0, state IDLE.
//     Back-to-back start held in the DONE cycle -> second done exactly 34 cycles after the first.

Source files
------------

// File: rtl/mul32_seq_if.sv
// Operand/result bundle between the EX stage and the iterative multiplier.
interface mul32_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             start;
   logic             is_signed;
   logic             flush;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] product_hi;
   logic             done;
   logic             busy;
   logic             stall;

   // Pipeline side: issues operands and control, observes results and stall.
   modport master (
      output A, B, start, is_signed, flush,
      input  product_lo, product_hi, done, busy, stall
   );

   // Multiplier side.
   modport slave (
      input  A, B, start, is_signed, flush,
      output product_lo, product_hi, done, busy, stall
   );
endinterface

// File: rtl/mul32_seq.sv
// Iterative radix-2 shift-add multiplier for unsigned and signed MUL.
// Operates on magnitudes and applies the sign in a final FIX cycle, so the
// latency is fixed at WIDTH+2 cycles from an accepted start to done.
module mul32_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic          clk,
   input logic          reset,
   mul32_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
   logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;

   logic               accept;
   logic               can_accept;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_full;
   logic [2*WIDTH-1:0] fix_val;

   // State, iteration counter and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mag_a_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         neg_q     <= 1'b0;
         prod_lo_q <= '0;
         prod_hi_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mag_a_q   <= mag_a_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         neg_q     <= neg_d;
         prod_lo_q <= prod_lo_d;
         prod_hi_q <= prod_hi_d;
      end
   end

   // Next-state logic and start acceptance; flush overrides everything.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (bus.flush) begin
         accept  = 1'b0;
         state_d = ST_IDLE;
      end
   end

   // Datapath: operand load, one shift-add step per RUN cycle, sign fix-up.
   always_comb begin
      cnt_d     = cnt_q;
      mag_a_d   = mag_a_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      neg_d     = neg_q;
      prod_lo_d = prod_lo_q;
      prod_hi_d = prod_hi_q;

      // Multiplier occupies the low half and is consumed as product bits
      // shift in from the top, so one 2*WIDTH register serves both roles.
      sum      = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_a_q : '0)};
      acc_full = {acc_hi_q, acc_lo_q};
      fix_val  = neg_q ? (~acc_full + (2*WIDTH)'(1)) : acc_full;

      if (accept) begin
         mag_a_d  = (bus.is_signed && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
         acc_lo_d = (bus.is_signed && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
         acc_hi_d = '0;
         neg_d    = bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
         cnt_d    = '0;
      end else if (state_q == ST_RUN) begin
         {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
         cnt_d                = cnt_q + CNT_W'(1);
      end else if ((state_q == ST_FIX) && !bus.flush) begin
         prod_hi_d = fix_val[2*WIDTH-1:WIDTH];
         prod_lo_d = fix_val[WIDTH-1:0];
      end
   end

   assign bus.product_lo = prod_lo_q;
   assign bus.product_hi = prod_hi_q;
   assign bus.done       = (state_q == ST_DONE);
   assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign bus.stall      = bus.busy | (bus.start & can_accept);

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed corner cases, handshake,
// flush, reset and back-to-back timing, plus randomized operands.
module tb_mul32_seq;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   mul32_seq_if #(.WIDTH(32)) bus ();

   mul32_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full 64-bit product from plain arithmetic.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic        [63:0] ua;
      logic        [63:0] ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (s) return 64'(sa * sb);
      return ua * ub;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a multiply in the current cycle (cycle 0) and returns in the
   // done cycle (34). Optionally pulses a spurious start at cycle `glitch`.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int glitch, input string tag);
      logic [63:0] exp;
      int dones;
      int stall_low;
      int busy_low;
      exp       = ref_mul(a, b, s);
      dones     = 0;
      stall_low = 0;
      busy_low  = 0;
      bus.A         = a;
      bus.B         = b;
      bus.is_signed = s;
      bus.start     = 1'b1;
      #1;
      chk({tag, " stall_c0"}, 64'(bus.stall), 64'd1);
      step();
      bus.start     = 1'b0;
      bus.A         = $urandom;
      bus.B         = $urandom;
      bus.is_signed = ~s;
      for (int c = 1; c <= 33; c++) begin
         if (c == glitch) begin
            bus.start = 1'b1;
            bus.A     = $urandom;
            bus.B     = $urandom;
            #1;
         end
         if (bus.done)   dones++;
         if (!bus.stall) stall_low++;
         if (!bus.busy)  busy_low++;
         step();
         bus.start = 1'b0;
      end
      chk({tag, " early_done"}, 64'(dones), 64'd0);
      chk({tag, " stall_gap"}, 64'(stall_low), 64'd0);
      chk({tag, " busy_gap"}, 64'(busy_low), 64'd0);
      chk({tag, " done_c34"}, 64'(bus.done), 64'd1);
      chk({tag, " product"}, {bus.product_hi, bus.product_lo}, exp);
      chk({tag, " stall_c34"}, 64'(bus.stall), 64'd0);
   endtask

   initial begin
      logic [63:0] prior;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int          dones;
      errors        = 0;
      checks        = 0;
      reset         = 1'b1;
      bus.A         = '0;
      bus.B         = '0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.flush     = 1'b0;

      // Reset state
      step();
      step();
      chk("rst product", {bus.product_hi, bus.product_lo}, 64'd0);
      chk("rst done", 64'(bus.done), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst stall", 64'(bus.stall), 64'd0);
      reset = 1'b0;
      step();

      // Directed products
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "umax");
      step();
      do_mul(32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 0, "sneg1x7");
      step();
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "sneg1xneg1");
      step();
      do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "smin");
      step();
      do_mul(32'h8000_0000, 32'h0000_0002, 1'b0, 0, "umsb");
      step();
      do_mul(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 0, "zero_neg");
      step();

      // Spurious start while busy is ignored and does not queue
      do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10, "ignore_start");
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (bus.done) dones++;
      end
      chk("no_queue done", 64'(dones), 64'd0);

      // Flush with concurrent start at cycle 15
      prior = {bus.product_hi, bus.product_lo};
      bus.A         = 32'hDEAD_BEEF;
      bus.B         = 32'h0BAD_F00D;
      bus.is_signed = 1'b1;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c < 15; c++) step();
      bus.flush = 1'b1;
      bus.start = 1'b1;
      bus.A     = 32'h0000_0003;
      bus.B     = 32'h0000_0005;
      step();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      #1;
      chk("flush busy", 64'(bus.busy), 64'd0);
      chk("flush stall", 64'(bus.stall), 64'd0);
      chk("flush done", 64'(bus.done), 64'd0);
      chk("flush keep", {bus.product_hi, bus.product_lo}, prior);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (bus.done) dones++;
      end
      chk("flush no_done", 64'(dones), 64'd0);
      chk("flush keep_late", {bus.product_hi, bus.product_lo}, prior);
      do_mul(32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 0, "post_flush");
      step();

      // Reset at cycle 20 of a multiply
      bus.A         = 32'h7FFF_FFFF;
      bus.B         = 32'h7FFF_FFFF;
      bus.is_signed = 1'b0;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c < 20; c++) step();
      reset = 1'b1;
      step();
      chk("midrst product", {bus.product_hi, bus.product_lo}, 64'd0);
      chk("midrst done", 64'(bus.done), 64'd0);
      chk("midrst busy", 64'(bus.busy), 64'd0);
      chk("midrst stall", 64'(bus.stall), 64'd0);
      reset = 1'b0;
      step();

      // Back-to-back: second start held in the DONE cycle
      do_mul(32'h0001_0001, 32'hFFFF_0000, 1'b0, 0, "b2b_first");
      do_mul(32'h8000_0001, 32'h0000_0003, 1'b1, 0, "b2b_second");
      do_mul(32'h0000_0001, 32'h8000_0000, 1'b1, 0, "b2b_third");
      step();

      // Randomized operands, occasionally forced to edge values
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h0000_0000;
            default: ;
         endcase
         do_mul(ra, rb, rs, 0, $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
